// File: rtl/proc_pkg.sv
// Shared constants for the processor control unit: opcodes, FSM step
// encoding and the bit positions of the III/XXX/YYY instruction fields.
package proc_pkg;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;

    localparam int III_MSB = 8;
    localparam int III_LSB = 6;
    localparam int XXX_MSB = 5;
    localparam int XXX_LSB = 3;
    localparam int YYY_MSB = 2;
    localparam int YYY_LSB = 0;

    // IR bit that selects subtract for the add/sub pair.
    localparam int ADDSUB_BIT = 6;

endpackage

// File: rtl/proc_control_unit_dec3to8.sv
// 3-to-8 one-hot decoder used to turn the XXX and YYY register fields
// into register enable / bus select vectors.
module dec3to8 (
    input  logic [2:0] w,
    output logic [7:0] y
);

    always_comb begin
        y = 8'b0000_0001 << w;
    end

endmodule

// File: rtl/proc_control_unit.sv
// Control FSM for a simple multi-cycle processor (mv, mvi, add, sub).
// Optional mvnz instruction enabled by defining PROC_CTRL_MVNZ_EN.
module proc_control_unit
    import proc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    input  logic              Gnz,
    output logic [NREGS-1:0]  Rin,
    output logic [NREGS-1:0]  Rout,
    output logic              Gout,
    output logic              DINout,
    output logic              Ain,
    output logic              Gin,
    output logic              AddSub,
    output logic              IRin,
    output logic              Done,
    output logic [1:0]        Tstep
);

    tstep_t     state;
    tstep_t     next_state;
    logic [8:0] ir;
    logic [2:0] opcode;
    logic [7:0] x_onehot;
    logic [7:0] y_onehot;

    assign opcode = ir[III_MSB:III_LSB];
    assign Tstep  = state;

    dec3to8 u_dec_x (
        .w (ir[XXX_MSB:XXX_LSB]),
        .y (x_onehot)
    );

    dec3to8 u_dec_y (
        .w (ir[YYY_MSB:YYY_LSB]),
        .y (y_onehot)
    );

    // Only DIN[8:0] carries the instruction; the upper bits are the immediate
    // and reach the datapath bus directly, not through this block.
`ifdef PROC_CTRL_MVNZ_EN
    logic unused_din_bits;
    assign unused_din_bits = ^DIN[DATA_W-1:9];
`else
    logic unused_din_bits;
    assign unused_din_bits = ^{DIN[DATA_W-1:9], Gnz};
`endif

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state <= T0;
            ir    <= 9'd0;
        end else begin
            state <= next_state;
            if (state == T0 && Run) begin
                ir <= DIN[8:0];
            end
        end
    end

    // Handshake: Run is a request sampled only in T0; IRin high marks the
    // cycle in which the request is accepted and IR is loaded. Run is
    // ignored while an instruction is executing (T1..T3).
    always_comb begin
        next_state = state;
        Rin        = '0;
        Rout       = '0;
        Gout       = 1'b0;
        DINout     = 1'b0;
        Ain        = 1'b0;
        Gin        = 1'b0;
        AddSub     = 1'b0;
        IRin       = 1'b0;
        Done       = 1'b0;

        case (state)
            T0: begin
                IRin       = Run;
                next_state = Run ? T1 : T0;
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        Rout       = y_onehot;
                        Rin        = x_onehot;
                        Done       = 1'b1;
                        next_state = T0;
                    end
                    OP_MVI: begin
                        DINout     = 1'b1;
                        Rin        = x_onehot;
                        Done       = 1'b1;
                        next_state = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        Rout       = x_onehot;
                        Ain        = 1'b1;
                        next_state = T2;
                    end
`ifdef PROC_CTRL_MVNZ_EN
                    OP_MVNZ: begin
                        if (Gnz) begin
                            Rout = y_onehot;
                            Rin  = x_onehot;
                        end
                        Done       = 1'b1;
                        next_state = T0;
                    end
`endif
                    default: begin
                        Done       = 1'b1;
                        next_state = T0;
                    end
                endcase
            end
            T2: begin
                Rout       = y_onehot;
                Gin        = 1'b1;
                AddSub     = ir[ADDSUB_BIT];
                next_state = T3;
            end
            T3: begin
                Gout       = 1'b1;
                Rin        = x_onehot;
                Done       = 1'b1;
                next_state = T0;
            end
            default: begin
                next_state = T0;
            end
        endcase
    end

endmodule

// File: tb/tb_proc_control_unit.sv
// Table-driven bench for proc_control_unit: one record per clock cycle with
// the inputs applied and the outputs expected in that cycle.
module tb_proc_control_unit;

    logic        Clock;
    logic        Resetn;
    logic        Run;
    logic [15:0] DIN;
    logic        Gnz;
    logic [7:0]  Rin;
    logic [7:0]  Rout;
    logic        Gout;
    logic        DINout;
    logic        Ain;
    logic        Gin;
    logic        AddSub;
    logic        IRin;
    logic        Done;
    logic [1:0]  Tstep;

    int n_compared   = 0;
    int n_mismatched = 0;

    // flag field order: {Gout, DINout, Ain, Gin, AddSub, IRin, Done}
    localparam logic [6:0] F_NONE = 7'b0000000;
    localparam logic [6:0] F_GOUT = 7'b1000000;
    localparam logic [6:0] F_DIN  = 7'b0100000;
    localparam logic [6:0] F_AIN  = 7'b0010000;
    localparam logic [6:0] F_GIN  = 7'b0001000;
    localparam logic [6:0] F_SUB  = 7'b0000100;
    localparam logic [6:0] F_IRIN = 7'b0000010;
    localparam logic [6:0] F_DONE = 7'b0000001;

    typedef struct {
        logic        resetn;
        logic        run;
        logic [15:0] din;
        logic        gnz;
        logic [24:0] exp;
    } vec_t;

    vec_t tbl[$];
    logic [24:0] exp_q[$];

    proc_control_unit dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Run    (Run),
        .DIN    (DIN),
        .Gnz    (Gnz),
        .Rin    (Rin),
        .Rout   (Rout),
        .Gout   (Gout),
        .DINout (DINout),
        .Ain    (Ain),
        .Gin    (Gin),
        .AddSub (AddSub),
        .IRin   (IRin),
        .Done   (Done),
        .Tstep  (Tstep)
    );

    // clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [24:0] ev(input logic [1:0] ts, input logic [7:0] rin,
                                       input logic [7:0] rout, input logic [6:0] flags);
        return {ts, rin, rout, flags};
    endfunction

    function automatic vec_t mk(input logic rst_n, input logic run, input logic [15:0] din,
                                input logic gnz, input logic [24:0] exp);
        vec_t v;
        v.resetn = rst_n;
        v.run    = run;
        v.din    = din;
        v.gnz    = gnz;
        v.exp    = exp;
        return v;
    endfunction

    // driver + checker: drive on negedge, sample 1 time unit later
    task automatic apply_check(input string name, input vec_t v);
        logic [24:0] act;
        logic [24:0] want;
        int          drivers;
        @(negedge Clock);
        Resetn = v.resetn;
        Run    = v.run;
        DIN    = v.din;
        Gnz    = v.gnz;
        exp_q.push_back(v.exp);
        #1;
        act  = {Tstep, Rin, Rout, Gout, DINout, Ain, Gin, AddSub, IRin, Done};
        want = exp_q.pop_front();
        n_compared++;
        if (act !== want) begin
            n_mismatched++;
            $display("FAIL %s: got ts=%0d rin=%b rout=%b flags=%b, want ts=%0d rin=%b rout=%b flags=%b",
                     name, act[24:23], act[22:15], act[14:7], act[6:0],
                     want[24:23], want[22:15], want[14:7], want[6:0]);
        end
        drivers = $countones(Rout) + int'(Gout) + int'(DINout);
        n_compared++;
        if (drivers > 1) begin
            n_mismatched++;
            $display("FAIL %s bus_drivers: got %0d active, want at most 1", name, drivers);
        end
    endtask

    localparam logic [15:0] I_MVI_R3    = 16'b001_011_000;
    localparam logic [15:0] I_ADD_R1_R2 = 16'b010_001_010;
    localparam logic [15:0] I_SUB_R0_R7 = 16'b011_000_111;
    localparam logic [15:0] I_MV_R5_R6  = 16'b000_101_110;
    localparam logic [15:0] I_NOP_111   = 16'b111_010_011;
    localparam logic [15:0] I_ADD_R2_R2 = 16'b010_010_010;
    localparam logic [15:0] I_MV_R1_R0  = 16'b000_001_000;
    localparam logic [15:0] I_MV_R2_R1  = 16'b000_010_001;
    localparam logic [15:0] I_MV_R3_R2  = 16'b000_011_010;
    localparam logic [15:0] I_MV_R4_R3  = 16'b000_100_011;
    localparam logic [15:0] I_MVNZ_R3R4 = 16'b100_011_100;

    initial begin
        logic [24:0] idle;
        logic [24:0] fetch;
        logic [24:0] mvnz_taken;
        idle  = ev(2'd0, 8'h00, 8'h00, F_NONE);
        fetch = ev(2'd0, 8'h00, 8'h00, F_IRIN);

        Resetn = 1'b0;
        Run    = 1'b0;
        DIN    = 16'h0000;
        Gnz    = 1'b0;
        repeat (2) @(posedge Clock);

        // mvi R3, #A5
        tbl.push_back(mk(1'b0, 1'b0, 16'h0000,    1'b0, idle));
        tbl.push_back(mk(1'b1, 1'b1, I_MVI_R3,    1'b0, fetch));
        tbl.push_back(mk(1'b1, 1'b0, 16'h00A5,    1'b0, ev(2'd1, 8'h08, 8'h00, F_DIN | F_DONE)));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000,    1'b0, idle));
        // add R1,R2
        tbl.push_back(mk(1'b1, 1'b1, I_ADD_R1_R2, 1'b0, fetch));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000,    1'b0, ev(2'd1, 8'h00, 8'h02, F_AIN)));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000,    1'b0, ev(2'd2, 8'h00, 8'h04, F_GIN)));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000,    1'b0, ev(2'd3, 8'h02, 8'h00, F_GOUT | F_DONE)));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000,    1'b0, idle));
        // sub R0,R7 with Run left high in T1 (must be ignored)
        tbl.push_back(mk(1'b1, 1'b1, I_SUB_R0_R7, 1'b0, fetch));
        tbl.push_back(mk(1'b1, 1'b1, I_MV_R5_R6,  1'b0, ev(2'd1, 8'h00, 8'h01, F_AIN)));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000,    1'b0, ev(2'd2, 8'h00, 8'h80, F_GIN | F_SUB)));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000,    1'b0, ev(2'd3, 8'h01, 8'h00, F_GOUT | F_DONE)));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000,    1'b0, idle));
        // mv R5,R6
        tbl.push_back(mk(1'b1, 1'b1, I_MV_R5_R6,  1'b0, fetch));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000,    1'b0, ev(2'd1, 8'h20, 8'h40, F_DONE)));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000,    1'b0, idle));
        // unsupported opcode 111 -> NOP
        tbl.push_back(mk(1'b1, 1'b1, I_NOP_111,   1'b0, fetch));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000,    1'b0, ev(2'd1, 8'h00, 8'h00, F_DONE)));
        // add R2,R2 (X=Y)
        tbl.push_back(mk(1'b1, 1'b1, I_ADD_R2_R2, 1'b0, fetch));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000,    1'b0, ev(2'd1, 8'h00, 8'h04, F_AIN)));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000,    1'b0, ev(2'd2, 8'h00, 8'h04, F_GIN)));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000,    1'b0, ev(2'd3, 8'h04, 8'h00, F_GOUT | F_DONE)));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000,    1'b0, idle));
        // three back-to-back mv with Run held high
        tbl.push_back(mk(1'b1, 1'b1, I_MV_R1_R0,  1'b0, fetch));
        tbl.push_back(mk(1'b1, 1'b1, I_MV_R2_R1,  1'b0, ev(2'd1, 8'h02, 8'h01, F_DONE)));
        tbl.push_back(mk(1'b1, 1'b1, I_MV_R2_R1,  1'b0, fetch));
        tbl.push_back(mk(1'b1, 1'b1, I_MV_R3_R2,  1'b0, ev(2'd1, 8'h04, 8'h02, F_DONE)));
        tbl.push_back(mk(1'b1, 1'b1, I_MV_R3_R2,  1'b0, fetch));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000,    1'b0, ev(2'd1, 8'h08, 8'h04, F_DONE)));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000,    1'b0, idle));
        // reset during T2 of add R1,R2, then mv R4,R3 completes normally
        tbl.push_back(mk(1'b1, 1'b1, I_ADD_R1_R2, 1'b0, fetch));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000,    1'b0, ev(2'd1, 8'h00, 8'h02, F_AIN)));
        tbl.push_back(mk(1'b0, 1'b0, 16'h0000,    1'b0, ev(2'd2, 8'h00, 8'h04, F_GIN)));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000,    1'b0, idle));
        tbl.push_back(mk(1'b1, 1'b1, I_MV_R4_R3,  1'b0, fetch));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000,    1'b0, ev(2'd1, 8'h10, 8'h08, F_DONE)));
        // reset wins over Run in T0: IR cleared, no fetch happens
        tbl.push_back(mk(1'b0, 1'b1, I_MV_R4_R3,  1'b0, fetch));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000,    1'b0, idle));

        for (int i = 0; i < tbl.size(); i++) begin
            apply_check($sformatf("vec%0d", i), tbl[i]);
        end

        // mvnz R3,R4: Gnz=0 never moves data; Gnz=1 moves only with the option
`ifdef PROC_CTRL_MVNZ_EN
        mvnz_taken = ev(2'd1, 8'h08, 8'h10, F_DONE);
`else
        mvnz_taken = ev(2'd1, 8'h00, 8'h00, F_DONE);
`endif
        apply_check("mvnz_gnz0_fetch", mk(1'b1, 1'b1, I_MVNZ_R3R4, 1'b0, fetch));
        apply_check("mvnz_gnz0_t1",    mk(1'b1, 1'b0, 16'h0000,    1'b0, ev(2'd1, 8'h00, 8'h00, F_DONE)));
        apply_check("mvnz_gnz0_idle",  mk(1'b1, 1'b0, 16'h0000,    1'b0, idle));
        apply_check("mvnz_gnz1_fetch", mk(1'b1, 1'b1, I_MVNZ_R3R4, 1'b1, fetch));
        apply_check("mvnz_gnz1_t1",    mk(1'b1, 1'b0, 16'h0000,    1'b1, mvnz_taken));
        apply_check("mvnz_gnz1_idle",  mk(1'b1, 1'b0, 16'h0000,    1'b0, idle));

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/proc_control_unit.md
PROC_CONTROL_UNIT -- requirements
Module: proc_control_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of DIN and of the datapath bus.
REQ-002 SHALL have parameter NREGS, default 8, register count; fixed at 8 by the 3-bit register fields.
REQ-003 SHALL have port Clock  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port Resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port Run  input  1  start request, sampled only in state T0.
REQ-006 SHALL have port DIN  input  DATA_W  instruction word in T0 (bits [8:0] = III XXX YYY); immediate in T1.
REQ-007 SHALL have port Gnz  input  1  G register non-zero flag from the datapath.
REQ-008 SHALL have port Rin  output  NREGS  one-hot write enable for R0..R7.
REQ-009 SHALL have port Rout  output  NREGS  one-hot bus-drive select for R0..R7.
REQ-010 SHALL have outputs Gout, DINout, Ain, Gin, AddSub, IRin, each 1 bit: G to bus, DIN to bus, load A, load G, 1 = subtract, load IR.
REQ-011 SHALL have port Done  output  1  instruction complete, one-cycle pulse.
REQ-012 SHALL have port Tstep  output  2  current state encoding, for debug.

Function
REQ-013 SHALL implement states T0, T1, T2, T3 (Tstep 0..3) with an internal 9-bit IR loaded from DIN[8:0] on posedge when state T0 and Run=1.
REQ-014 SHALL keep all control outputs combinational from state and IR; at most one of Rout, Gout, DINout SHALL be active in any cycle.
REQ-015 In T0: IRin=Run, all other outputs 0; T0->T1 when Run=1, else stay in T0.
REQ-016 Opcode 000 mv: T1 Rout[Y]=1, Rin[X]=1, Done=1, then T1->T0.
REQ-017 Opcode 001 mvi: T1 DINout=1, Rin[X]=1, Done=1, then T1->T0.
REQ-018 Opcode 010 add / 011 sub: T1 Rout[X], Ain; T2 Rout[Y], Gin, AddSub=IR[6]; T3 Gout, Rin[X], Done; T3->T0.
REQ-019 Unsupported opcodes SHALL act as a NOP: T1 Done=1 with no enables, then T1->T0.
REQ-020 Done SHALL be high for exactly one cycle per instruction; latency from Run acceptance to Done is 1 cycle for mv, mvi and NOP, and 3 cycles for add/sub.
REQ-021 Run SHALL be ignored in T1 to T3; a Run held high across Done starts the next fetch in the T0 cycle immediately following.
REQ-022 When X=Y, the decode SHALL be unchanged (for example, add R2,R2 doubles R2).

Reset
REQ-023 Resetn=0 at posedge SHALL force state T0 and IR=0 regardless of current state, including mid-instruction.
REQ-024 While in T0 after reset, all outputs except IRin SHALL be 0; no Rin pulse SHALL be emitted for an aborted instruction.

Configuration
REQ-025 Macro PROC_CTRL_MVNZ_EN defined: opcode 100 mvnz SHALL, in T1, assert Rout[Y] and Rin[X] only if Gnz=1, and assert Done in either case.
REQ-026 Macro PROC_CTRL_MVNZ_EN undefined: opcode 100 SHALL behave as a NOP per REQ-019, and Gnz SHALL be unused.

Structure
REQ-027 Package proc_pkg SHALL hold the opcode constants (OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_MVNZ), the state encoding T0..T3, and the field positions of III, XXX and YYY.
REQ-028 A sub-module dec3to8 SHALL convert the X and Y fields to one-hot form; it is used for both Rin and Rout.

Verification
REQ-029 Reset, then Run=1 with DIN=9'b001_011_000 and DIN=16'h00A5 in T1 -> T1 shows DINout=1, Rin=8'b0000_1000, Done=1; next state T0.
REQ-030 add R1,R2 (DIN=9'b010_001_010) -> T1 Rout=0000_0010 and Ain; T2 Rout=0000_0100, Gin, AddSub=0; T3 Gout, Rin=0000_0010, Done; 4 cycles total including T0.
REQ-031 sub R0,R7 -> AddSub=1 in T2 only; Done only in T3.
REQ-032 Resetn=0 during T2 of an add -> next cycle Tstep=0, Rin=0, no Done; a new mv completes normally afterwards.
REQ-033 mvnz R3,R4 with the macro defined: Gnz=0 -> Done=1 with Rin=0; Gnz=1 -> Rout=0001_0000, Rin=0000_1000. With the macro undefined -> Done=1 with Rin=0.
REQ-034 Run held high for 3 back-to-back mv instructions -> exactly 3 Done pulses, and IRin is asserted only in T0 cycles.
